axi_mem_responder: RTL

- AXI4 subordinate (responder) memory that sits at the far end of the cache's data and instruction AXI master ports.
- Serves single-beat data reads and writes, and 16-beat INCR instruction-line fills.
- Backed by an internal word array, with a backdoor load port used to preload programs for simulation and FPGA bring-up.
- The read and write channels are independent; each accepts one outstanding transaction.

---
 rtl/axi_mem_responder.sv | 307 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_responder.sv
// axi_mem_responder
//   AXI4 subordinate memory that sits behind the cache's data and instruction
//   master ports. It serves single-beat reads and writes and INCR/FIXED bursts
//   of up to 256 beats. A backdoor port preloads words for simulation and
//   FPGA bring-up. The read and write channels are independent, and each one
//   holds a single outstanding transaction.
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   init_valid/addr/data        backdoor word write (highest priority)
//   s_aw*, s_w*, s_b*           AXI write address / data / response channels
//   s_ar*, s_r*                 AXI read address / data channels
module axi_mem_responder #(
    parameter int unsigned ADDR_BITS = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 init_valid,
    input  logic [ADDR_BITS-1:0] init_addr,
    input  logic [31:0]          init_data,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [31:0]          s_awaddr,
    input  logic [7:0]           s_awlen,
    input  logic [2:0]           s_awsize,
    input  logic [1:0]           s_awburst,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    input  logic [31:0]          s_wdata,
    input  logic [3:0]           s_wstrb,
    input  logic                 s_wlast,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    output logic [1:0]           s_bresp,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    input  logic [31:0]          s_araddr,
    input  logic [7:0]           s_arlen,
    input  logic [2:0]           s_arsize,
    input  logic [1:0]           s_arburst,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    output logic [31:0]          s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 s_rlast
);
    localparam int unsigned DEPTH = 1 << ADDR_BITS;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic       {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'b00, W_DATA = 2'b01, W_RESP = 2'b10} w_state_t;

    logic [31:0] mem [DEPTH];

    function automatic logic [31:0] word_index(input logic [31:0] addr);
        return (addr - BASE_ADDR) >> 2;
    endfunction

    // Addresses below the base wrap to huge indices, but are rejected explicitly too.
    function automatic logic in_range(input logic [31:0] addr, input logic [31:0] idx);
        return (addr >= BASE_ADDR) && ((idx >> ADDR_BITS) == 32'd0);
    endfunction

    // Only 32-bit beats of FIXED or INCR bursts are supported.
    function automatic logic txn_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || burst[1];
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
        return (burst == BURST_INCR) ? addr + 32'd4 : addr;
    endfunction

    function automatic logic [1:0] resp_code(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

    // ---------------- read channel ----------------
    r_state_t    r_state_r, r_state_s;
    logic [31:0] r_addr_r, r_addr_s;
    logic [7:0]  r_len_r, r_len_s, r_cnt_r, r_cnt_s;
    logic [1:0]  r_burst_r, r_burst_s;
    logic        r_bad_r, r_bad_s;
    logic        arready_s, rvalid_s, rlast_s;
    logic [31:0] rdata_s;
    logic [1:0]  rresp_s;
    logic [31:0] r_pick_addr_s, r_pick_idx_s, r_pick_data_s;
    logic        r_pick_bad_s, r_pick_err_s;

    // Address of the beat presented next: the AR address when idle, else the successor beat.
    always_comb begin
        if (r_state_r == R_DATA) begin
            r_pick_addr_s = next_addr(r_addr_r, r_burst_r);
            r_pick_bad_s  = r_bad_r;
        end else begin
            r_pick_addr_s = s_araddr;
            r_pick_bad_s  = txn_bad(s_arsize, s_arburst);
        end
    end

    assign r_pick_idx_s  = word_index(r_pick_addr_s);
    assign r_pick_err_s  = r_pick_bad_s || !in_range(r_pick_addr_s, r_pick_idx_s);
    assign r_pick_data_s = r_pick_err_s ? 32'd0 : mem[r_pick_idx_s[ADDR_BITS-1:0]];

    // Read FSM next-state and next registered outputs.
    always_comb begin
        r_state_s = r_state_r;
        r_addr_s  = r_addr_r;
        r_len_s   = r_len_r;
        r_cnt_s   = r_cnt_r;
        r_burst_s = r_burst_r;
        r_bad_s   = r_bad_r;
        arready_s = s_arready;
        rvalid_s  = s_rvalid;
        rdata_s   = s_rdata;
        rresp_s   = s_rresp;
        rlast_s   = s_rlast;
        case (r_state_r)
            R_IDLE: begin
                if (s_arvalid && s_arready) begin
                    r_state_s = R_DATA;
                    r_addr_s  = s_araddr;
                    r_len_s   = s_arlen;
                    r_cnt_s   = 8'd0;
                    r_burst_s = s_arburst;
                    r_bad_s   = r_pick_bad_s;
                    arready_s = 1'b0;
                    rvalid_s  = 1'b1;
                    rdata_s   = r_pick_data_s;
                    rresp_s   = resp_code(r_pick_err_s);
                    rlast_s   = (s_arlen == 8'd0);
                end else begin
                    arready_s = 1'b1;
                end
            end
            R_DATA: begin
                if (s_rvalid && s_rready) begin
                    if (s_rlast) begin
                        r_state_s = R_IDLE;
                        rvalid_s  = 1'b0;
                        rlast_s   = 1'b0;
                        arready_s = 1'b1;
                    end else begin
                        r_addr_s = r_pick_addr_s;
                        r_cnt_s  = r_cnt_r + 8'd1;
                        rdata_s  = r_pick_data_s;
                        rresp_s  = resp_code(r_pick_err_s);
                        rlast_s  = ((r_cnt_r + 8'd1) == r_len_r);
                    end
                end else begin
                    r_state_s = R_DATA;
                end
            end
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read FSM state and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_r <= R_IDLE;
            r_addr_r  <= 32'd0;
            r_len_r   <= 8'd0;
            r_cnt_r   <= 8'd0;
            r_burst_r <= 2'b00;
            r_bad_r   <= 1'b0;
            s_arready <= 1'b0;
            s_rvalid  <= 1'b0;
            s_rdata   <= 32'd0;
            s_rresp   <= 2'b00;
            s_rlast   <= 1'b0;
        end else begin
            r_state_r <= r_state_s;
            r_addr_r  <= r_addr_s;
            r_len_r   <= r_len_s;
            r_cnt_r   <= r_cnt_s;
            r_burst_r <= r_burst_s;
            r_bad_r   <= r_bad_s;
            s_arready <= arready_s;
            s_rvalid  <= rvalid_s;
            s_rdata   <= rdata_s;
            s_rresp   <= rresp_s;
            s_rlast   <= rlast_s;
        end
    end

    // ---------------- write channel ----------------
    w_state_t    w_state_r, w_state_s;
    logic [31:0] w_addr_r, w_addr_s, w_idx_s;
    logic [7:0]  w_len_r, w_len_s, w_cnt_r, w_cnt_s;
    logic [1:0]  w_burst_r, w_burst_s;
    logic        w_bad_r, w_bad_s, w_err_r, w_err_s;
    logic        awready_s, wready_s, bvalid_s;
    logic [1:0]  bresp_s;
    logic        w_fire_s, w_beat_err_s, w_last_beat_s, w_err_upd_s, mem_we_s;

    assign w_idx_s       = word_index(w_addr_r);
    assign w_beat_err_s  = w_bad_r || !in_range(w_addr_r, w_idx_s);
    assign w_fire_s      = (w_state_r == W_DATA) && s_wvalid && s_wready;
    assign w_last_beat_s = (w_cnt_r == w_len_r);
    // A WLAST that disagrees with the beat count poisons the response but not the data.
    assign w_err_upd_s   = w_err_r || w_beat_err_s || (s_wlast != w_last_beat_s);
    assign mem_we_s      = w_fire_s && !w_beat_err_s;

    // Write FSM next-state and next registered outputs.
    always_comb begin
        w_state_s = w_state_r;
        w_addr_s  = w_addr_r;
        w_len_s   = w_len_r;
        w_cnt_s   = w_cnt_r;
        w_burst_s = w_burst_r;
        w_bad_s   = w_bad_r;
        w_err_s   = w_err_r;
        awready_s = s_awready;
        wready_s  = s_wready;
        bvalid_s  = s_bvalid;
        bresp_s   = s_bresp;
        case (w_state_r)
            W_IDLE: begin
                if (s_awvalid && s_awready) begin
                    w_state_s = W_DATA;
                    w_addr_s  = s_awaddr;
                    w_len_s   = s_awlen;
                    w_cnt_s   = 8'd0;
                    w_burst_s = s_awburst;
                    w_bad_s   = txn_bad(s_awsize, s_awburst);
                    w_err_s   = 1'b0;
                    awready_s = 1'b0;
                    wready_s  = 1'b1;
                end else begin
                    awready_s = 1'b1;
                end
            end
            W_DATA: begin
                if (w_fire_s) begin
                    w_err_s = w_err_upd_s;
                    if (w_last_beat_s) begin
                        w_state_s = W_RESP;
                        wready_s  = 1'b0;
                        bvalid_s  = 1'b1;
                        bresp_s   = resp_code(w_err_upd_s);
                    end else begin
                        w_addr_s = next_addr(w_addr_r, w_burst_r);
                        w_cnt_s  = w_cnt_r + 8'd1;
                    end
                end else begin
                    w_state_s = W_DATA;
                end
            end
            W_RESP: begin
                if (s_bvalid && s_bready) begin
                    w_state_s = W_IDLE;
                    bvalid_s  = 1'b0;
                    awready_s = 1'b1;
                end else begin
                    w_state_s = W_RESP;
                end
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write FSM state and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_r <= W_IDLE;
            w_addr_r  <= 32'd0;
            w_len_r   <= 8'd0;
            w_cnt_r   <= 8'd0;
            w_burst_r <= 2'b00;
            w_bad_r   <= 1'b0;
            w_err_r   <= 1'b0;
            s_awready <= 1'b0;
            s_wready  <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= 2'b00;
        end else begin
            w_state_r <= w_state_s;
            w_addr_r  <= w_addr_s;
            w_len_r   <= w_len_s;
            w_cnt_r   <= w_cnt_s;
            w_burst_r <= w_burst_s;
            w_bad_r   <= w_bad_s;
            w_err_r   <= w_err_s;
            s_awready <= awready_s;
            s_wready  <= wready_s;
            s_bvalid  <= bvalid_s;
            s_bresp   <= bresp_s;
        end
    end

    // Memory array: not reset; backdoor wins over an AXI write to the same word.
    always_ff @(posedge clk) begin
        if (init_valid) begin
            mem[init_addr] <= init_data;
        end
        if (mem_we_s && !(init_valid && (init_addr == w_idx_s[ADDR_BITS-1:0]))) begin
            for (int i = 0; i < 4; i++) begin
                if (s_wstrb[i]) begin
                    mem[w_idx_s[ADDR_BITS-1:0]][8*i +: 8] <= s_wdata[8*i +: 8];
                end
            end
        end
    end
endmodule
